// File: rtl/pipelined_alu.sv
// ---------------------------------------------------------------------------
// pipelined_alu
//
// Single-issue ALU with a ready/valid elastic pipeline. The result is computed
// combinationally from the accepted operands and captured in stage 1. Each
// later stage only forwards it. A stage loads when it is empty or when the
// stage after it loads, so bubbles collapse. A full pipeline still accepts
// when the final stage is popped in the same cycle.
//
// Parameters
//   WIDTH  : operand/result width (8..64)
//   STAGES : number of register stages = unstalled latency (1..8)
//   TAG_W  : sideband tag width
//   SAT    : 1 = signed saturation on ADD/SUB overflow
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready depends on out_ready)
//   a, b, alu_op        : operands and operation select
//   in_tag              : sideband tag carried with the operation
//   out_valid/out_ready : downstream handshake
//   result, out_tag     : result and its tag (registered)
//   flags               : {err, ovf, neg, zero} of the result (registered)
// ---------------------------------------------------------------------------
module pipelined_alu #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic [3:0]              alu_op,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] result,
    output logic [TAG_W-1:0]        out_tag,
    output logic [3:0]              flags
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRA  = 4'd6,
        OP_SLT  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MIN  = 4'd10,
        OP_MAX  = 4'd11,
        OP_MINU = 4'd12,
        OP_MAXU = 4'd13
    } alu_op_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;   // {err, ovf, neg, zero}
    } stage_t;

    // -----------------------------------------------------------------------
    // Combinational ALU
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_raw;
    logic [WIDTH-1:0] res_sat;
    logic [SH_W-1:0]  shamt;
    logic             ovf;
    logic             err;

    // NOTE: every variable driven here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        shamt   = b[SH_W-1:0];
        res_raw = '0;
        ovf     = 1'b0;
        err     = 1'b0;

        case (alu_op)
            OP_ADD: begin
                res_raw = sum;
                // Signed overflow: operands agree in sign, result does not.
                ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_raw = diff;
                // Signed overflow: operands differ in sign, result sign differs from a.
                ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_raw = a & b;
            OP_OR:   res_raw = a | b;
            OP_XOR:  res_raw = a ^ b;
            OP_SLL:  res_raw = a << shamt;
            OP_SRA:  res_raw = a >>> shamt;             // a is signed: sign fill
            OP_SLT:  res_raw = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRL:  res_raw = $unsigned(a) >> shamt;
            OP_SLTU: res_raw = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            OP_MIN:  res_raw = (a < b) ? a : b;
            OP_MAX:  res_raw = (a < b) ? b : a;
            OP_MINU: res_raw = ($unsigned(a) < $unsigned(b)) ? a : b;
            OP_MAXU: res_raw = ($unsigned(a) < $unsigned(b)) ? b : a;
            default: err     = 1'b1;                    // opcodes 14, 15
        endcase

        // Overflow direction follows the sign of a for both ADD and SUB.
        res_sat = res_raw;
        if ((SAT != 0) && ovf) begin
            res_sat = a[WIDTH-1] ? SMIN : SMAX;
        end
    end

    stage_t in_stage;

    always_comb begin
        in_stage.valid  = in_valid;
        in_stage.result = res_sat;
        in_stage.tag    = in_tag;
        in_stage.flags  = {err, ovf, res_sat[WIDTH-1], (res_sat == '0)};
    end

    // -----------------------------------------------------------------------
    // Pipeline control
    // -----------------------------------------------------------------------
    stage_t            pipe [STAGES];
    logic [STAGES-1:0] load;

    // Stage k stalls only when it and every stage after it are full and the
    // output is not consumed. Written per stage rather than as a chain so no
    // bit of load depends on another bit of the same vector.
    always_comb begin : load_calc
        logic full_run;
        full_run = 1'b0;
        load     = '0;
        for (int k = 0; k < STAGES; k++) begin
            full_run = !out_ready;
            for (int j = k; j < STAGES; j++) begin
                full_run = full_run & pipe[j].valid;
            end
            load[k] = !full_run;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, independent of loop order.
    // NOTE: data fields are reset along with valid so result, out_tag and
    // flags read zero during reset, not only out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                pipe[0] <= in_stage;
            end
            // A loading stage takes its predecessor even when that is empty:
            // that is how bubbles collapse.
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    pipe[k] <= pipe[k-1];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = pipe[STAGES-1].valid;
    assign result    = pipe[STAGES-1].result;
    assign out_tag   = pipe[STAGES-1].tag;
    assign flags     = pipe[STAGES-1].flags;

endmodule
